// File: rtl/instruction_fetcher_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetcher_pkg
// Shared definitions for the instruction fetch front end:
//   - opcode constants used by the predecoder (JAL, B-type branch)
//   - TRUE/FALSE single-bit constants
//   - fetch FSM state encoding
//   - BHT counter reset value
//   - immediate extraction helpers for J-type and B-type encodings
// -----------------------------------------------------------------------------
package instruction_fetcher_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Weakly not-taken: a single taken outcome flips the prediction.
  localparam logic [1:0] BHT_RESET = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  // J-type immediate: {i[31], i[19:12], i[20], i[30:21], 0}, sign-extended.
  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // B-type immediate: {i[31], i[7], i[30:25], i[11:8], 0}, sign-extended.
  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/instruction_fetcher_bht.sv
// -----------------------------------------------------------------------------
// branch_history_table
// Array of 2-bit saturating counters used to predict B-type branches.
// Ports:
//   clk_in        system clock
//   rst_in        synchronous active-low reset, all counters to 2'b01
//   rdy_in        global pause; counters hold when low
//   rd_idx_in     read index (combinational read, sees the pre-update value)
//   rd_ctr_out    counter value at rd_idx_in
//   upd_en_in     apply one outcome to counter upd_idx_in
//   upd_idx_in    index of the counter to update
//   upd_taken_in  1 = increment, 0 = decrement (both saturating)
// -----------------------------------------------------------------------------
module branch_history_table
  import instruction_fetcher_pkg::*;
#(
  parameter int INDEX_W = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic [INDEX_W-1:0] rd_idx_in,
  output logic [1:0]         rd_ctr_out,
  input  logic               upd_en_in,
  input  logic [INDEX_W-1:0] upd_idx_in,
  input  logic               upd_taken_in
);

  localparam int ENTRIES = 1 << INDEX_W;

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d [ENTRIES];

  // Read of the registered array: a same-cycle update is not yet visible.
  assign rd_ctr_out = ctr_q[rd_idx_in];

  always_comb begin
    ctr_d = ctr_q;
    if (upd_en_in) begin
      if (upd_taken_in && (ctr_q[upd_idx_in] != 2'b11)) begin
        ctr_d[upd_idx_in] = ctr_q[upd_idx_in] + 2'd1;
      end else if (!upd_taken_in && (ctr_q[upd_idx_in] != 2'b00)) begin
        ctr_d[upd_idx_in] = ctr_q[upd_idx_in] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= BHT_RESET;
      end
    end else if (rdy_in) begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// -----------------------------------------------------------------------------
// instruction_fetcher
// Front end that feeds the instruction queue. Holds the fetch PC, issues one
// icache word request at a time, predecodes the returned word (JAL / B-type
// with a BHT lookup) to pick the next PC, and pushes {instr, pc, prediction}
// into the queue. A roll_back from the ROB redirects the PC; a response that
// was already in flight at that moment is drained and discarded (FLUSH).
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (global pause)
//   roll_back, roll_back_pc_in                   ROB redirect
//   bht_update_in, bht_update_pc_in, bht_taken_in  committed branch outcome
//   icache_req_out, icache_addr_out              request to icache
//   icache_valid_in, icache_data_in              icache response strobe/data
//   isq_full_in                                  queue full flag
//   instruction_ready, instruction_out, pc_out, pc_predict_out  queue push
// -----------------------------------------------------------------------------
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          BHT_INDEX_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic [31:0] roll_back_pc_in,
  input  logic        bht_update_in,
  input  logic [31:0] bht_update_pc_in,
  input  logic        bht_taken_in,
  output logic        icache_req_out,
  output logic [31:0] icache_addr_out,
  input  logic        icache_valid_in,
  input  logic [31:0] icache_data_in,
  input  logic        isq_full_in,
  output logic        instruction_ready,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        pc_predict_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic         ready_q, ready_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         pred_q, pred_d;

  logic [1:0]   bht_ctr;
  logic         pred_taken;
  logic [31:0]  next_pc;
  logic         unused_upd_pc_bits;

  assign unused_upd_pc_bits = ^{bht_update_pc_in[31:BHT_INDEX_W+2], bht_update_pc_in[1:0]};

  branch_history_table #(
    .INDEX_W (BHT_INDEX_W)
  ) u_bht (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .rd_idx_in    (fetch_addr_q[BHT_INDEX_W+1:2]),
    .rd_ctr_out   (bht_ctr),
    .upd_en_in    (bht_update_in),
    .upd_idx_in   (bht_update_pc_in[BHT_INDEX_W+1:2]),
    .upd_taken_in (bht_taken_in)
  );

  // Predecode of the returned word; fetch_addr_q is the PC of that word.
  always_comb begin
    pred_taken = FALSE;
    next_pc    = fetch_addr_q + 32'd4;
    unique case (icache_data_in[6:0])
      OPC_JAL: begin
        pred_taken = TRUE;
        next_pc    = fetch_addr_q + imm_j(icache_data_in);
      end
      OPC_BRANCH: begin
        pred_taken = bht_ctr[1];
        if (bht_ctr[1]) begin
          next_pc = fetch_addr_q + imm_b(icache_data_in);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    ready_d      = ready_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    pred_d       = pred_q;
    if (rdy_in) begin
      ready_d = FALSE;
      if (roll_back) begin
        pc_d = roll_back_pc_in;
        // A request still in flight must be drained before a new one is
        // issued, otherwise its late response would be taken as the new word.
        if ((state_q != ST_IDLE) && !icache_valid_in) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            // Waiting one cycle after a push lets isq_full_in catch up.
            if (!isq_full_in && !ready_q) begin
              state_d      = ST_WAIT;
              fetch_addr_d = pc_q;
            end
          end
          ST_WAIT: begin
            if (icache_valid_in) begin
              instr_d  = icache_data_in;
              pc_out_d = fetch_addr_q;
              pred_d   = pred_taken;
              ready_d  = TRUE;
              pc_d     = next_pc;
              state_d  = ST_IDLE;
            end
          end
          ST_FLUSH: begin
            if (icache_valid_in) begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= 32'h0;
      ready_q      <= FALSE;
      instr_q      <= 32'h0;
      pc_out_q     <= 32'h0;
      pred_q       <= FALSE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      ready_q      <= ready_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      pred_q       <= pred_d;
    end
  end

  assign icache_req_out    = (state_q != ST_IDLE);
  assign icache_addr_out   = fetch_addr_q;
  assign instruction_ready = ready_q;
  assign instruction_out   = instr_q;
  assign pc_out            = pc_out_q;
  assign pc_predict_out    = pred_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetcher
// Directed bench for instruction_fetcher. A transaction-level model predicts
// every push (word, pc, prediction) and every new fetch address from the
// words the icache responder hands out, the roll_back redirects and the BHT
// outcomes; a compare process checks the DUT against it on every cycle.
// Directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_instruction_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic [31:0] roll_back_pc_in;
  logic        bht_update_in;
  logic [31:0] bht_update_pc_in;
  logic        bht_taken_in;
  logic        icache_req_out;
  logic [31:0] icache_addr_out;
  logic        icache_valid_in;
  logic [31:0] icache_data_in;
  logic        isq_full_in;
  logic        instruction_ready;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        pc_predict_out;

  always #5 clk_in = ~clk_in;

  instruction_fetcher #(
    .RESET_PC    (32'h0),
    .BHT_INDEX_W (4)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .roll_back         (roll_back),
    .roll_back_pc_in   (roll_back_pc_in),
    .bht_update_in     (bht_update_in),
    .bht_update_pc_in  (bht_update_pc_in),
    .bht_taken_in      (bht_taken_in),
    .icache_req_out    (icache_req_out),
    .icache_addr_out   (icache_addr_out),
    .icache_valid_in   (icache_valid_in),
    .icache_data_in    (icache_data_in),
    .isq_full_in       (isq_full_in),
    .instruction_ready (instruction_ready),
    .instruction_out   (instruction_out),
    .pc_out            (pc_out),
    .pc_predict_out    (pc_predict_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- program memory seen by the icache responder ----------
  logic [31:0] imem [logic [31:0]];

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return 32'h0000_0013;
  endfunction

  // ---------------- icache responder ------------------------------------
  int lat = 1;
  int rcnt;

  initial begin
    icache_valid_in = 1'b0;
    icache_data_in  = 32'h0;
    rcnt = 0;
    forever begin
      @(posedge clk_in);
      #1;
      if (!rst_in) begin
        icache_valid_in = 1'b0;
        rcnt = 0;
      end else if (rdy_in) begin
        if (icache_valid_in) begin
          icache_valid_in = 1'b0;
          rcnt = 0;
        end else if (icache_req_out) begin
          if (rcnt >= lat) begin
            icache_valid_in = 1'b1;
            icache_data_in  = fetch_word(icache_addr_out);
            rcnt = 0;
          end else begin
            rcnt++;
          end
        end
      end
    end
  end

  // ---------------- transaction-level model -----------------------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } push_t;

  push_t       exp_q [$];
  int          bht_m [16];
  logic [31:0] model_pc;
  logic        flush_pending;
  logic        req_at_neg;
  logic        edge_rdy;
  int          cyc;

  initial begin
    cyc = 0;
    model_pc = 32'h0;
    flush_pending = 1'b0;
    edge_rdy = 1'b0;
    forever begin
      @(posedge clk_in);
      cyc++;
      if (!rst_in) begin
        exp_q.delete();
        model_pc = 32'h0;
        flush_pending = 1'b0;
        edge_rdy = 1'b0;
        for (int i = 0; i < 16; i++) bht_m[i] = 1;
      end else begin
        edge_rdy = rdy_in;
        if (rdy_in) begin
          if (icache_valid_in) begin
            if (!flush_pending && !roll_back) begin
              logic [31:0]        w;
              logic signed [20:0] jimm;
              logic signed [12:0] bimm;
              push_t              e;
              w    = icache_data_in;
              jimm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
              bimm = {w[31], w[7], w[30:25], w[11:8], 1'b0};
              e.instr = w;
              e.pc    = model_pc;
              e.pred  = 1'b0;
              if (w[6:0] == 7'b1101111) begin
                e.pred   = 1'b1;
                model_pc = model_pc + 32'($signed(jimm));
              end else if (w[6:0] == 7'b1100011 && bht_m[model_pc[5:2]] >= 2) begin
                e.pred   = 1'b1;
                model_pc = model_pc + 32'($signed(bimm));
              end else begin
                model_pc = model_pc + 32'd4;
              end
              exp_q.push_back(e);
            end
            flush_pending = 1'b0;
          end
          if (roll_back) begin
            model_pc = roll_back_pc_in;
            if (req_at_neg && !icache_valid_in) flush_pending = 1'b1;
          end
          if (bht_update_in) begin
            if (bht_taken_in && bht_m[bht_update_pc_in[5:2]] < 3)
              bht_m[bht_update_pc_in[5:2]]++;
            else if (!bht_taken_in && bht_m[bht_update_pc_in[5:2]] > 0)
              bht_m[bht_update_pc_in[5:2]]--;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare -----------------------------------
  initial begin
    logic        prev_req;
    logic [31:0] cur_addr;
    push_t       e;
    prev_req   = 1'b0;
    cur_addr   = 32'h0;
    req_at_neg = 1'b0;
    forever begin
      @(negedge clk_in);
      req_at_neg = icache_req_out;
      if (rst_in) begin
        if (instruction_ready && edge_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_push: got pc %h expected no push", pc_out);
          end else begin
            e = exp_q.pop_front();
            chk("push_instr", instruction_out, e.instr);
            chk("push_pc", pc_out, e.pc);
            chk("push_pred", {31'h0, pc_predict_out}, {31'h0, e.pred});
          end
        end
        if (icache_req_out && !prev_req) begin
          chk("req_addr", icache_addr_out, model_pc);
          cur_addr = icache_addr_out;
        end else if (icache_req_out) begin
          chk("req_addr_stable", icache_addr_out, cur_addr);
        end
      end
      prev_req = icache_req_out;
    end
  end

  // ---------------- directed helpers ------------------------------------
  task automatic wait_push(output logic [31:0] w, output logic [31:0] p,
                           output logic pr, output int t);
    bit found = 0;
    w = 0; p = 0; pr = 0; t = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk_in);
      if (instruction_ready) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got no push expected one within 60 cycles");
    end else begin
      w = instruction_out; p = pc_out; pr = pc_predict_out; t = cyc;
    end
  endtask

  task automatic wait_req(output logic [31:0] a);
    logic prev;
    bit   found = 0;
    a = 32'hFFFF_FFFF;
    prev = icache_req_out;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk_in);
      if (icache_req_out && !prev) begin
        found = 1;
        a = icache_addr_out;
        break;
      end
      prev = icache_req_out;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no request expected one within 60 cycles");
    end
  endtask

  task automatic wait_push_pc(input logic [31:0] target, output logic [31:0] w,
                              output logic pr);
    logic [31:0] p;
    int          t;
    bit          found = 0;
    w = 0; pr = 0;
    for (int k = 0; k < 12; k++) begin
      wait_push(w, p, pr, t);
      if (p == target) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL push_pc_timeout: got no push at %h expected one", target);
    end
  endtask

  // ---------------- directed stimulus -----------------------------------
  initial begin
    logic [31:0] w, p, a;
    logic        pr;
    int          t1, t2;

    rst_in = 1'b0; rdy_in = 1'b1; roll_back = 1'b0; roll_back_pc_in = 32'h0;
    bht_update_in = 1'b0; bht_update_pc_in = 32'h0; bht_taken_in = 1'b0;
    isq_full_in = 1'b0; lat = 1;
    imem[32'h10] = 32'h0080_006F;   // jal +8
    imem[32'h20] = 32'hFE00_0EE3;   // beq -4

    repeat (3) @(negedge clk_in);
    chk("rst_req", {31'h0, icache_req_out}, 32'h0);
    chk("rst_addr", icache_addr_out, 32'h0);
    chk("rst_ready", {31'h0, instruction_ready}, 32'h0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_pred", {31'h0, pc_predict_out}, 32'h0);
    @(posedge clk_in); #2; rst_in = 1'b1;

    // Sequential addi stream at latency 1.
    wait_push(w, p, pr, t1);
    chk("p0_pc", p, 32'h0);
    chk("p0_instr", w, 32'h0000_0013);
    chk("p0_pred", {31'h0, pr}, 32'h0);
    wait_req(a);
    chk("p0_next_addr", a, 32'h4);
    wait_push(w, p, pr, t2);
    chk("p1_pc", p, 32'h4);
    chk("push_spacing", 32'(t2 - t1), 32'd4);

    // JAL at 0x10 jumps to 0x18.
    wait_push_pc(32'h10, w, pr);
    chk("jal_instr", w, 32'h0080_006F);
    chk("jal_pred", {31'h0, pr}, 32'h1);
    wait_req(a);
    chk("jal_target", a, 32'h18);

    // Fresh BHT: beq at 0x20 predicted not taken.
    wait_push_pc(32'h20, w, pr);
    chk("beq_fresh_pred", {31'h0, pr}, 32'h0);
    wait_req(a);
    chk("beq_fresh_next", a, 32'h24);

    // Train the counter twice taken, then refetch 0x20.
    @(posedge clk_in); #2;
    bht_update_in = 1'b1; bht_update_pc_in = 32'h20; bht_taken_in = 1'b1;
    @(posedge clk_in); #2;
    @(posedge clk_in); #2;
    bht_update_in = 1'b0;
    roll_back = 1'b1; roll_back_pc_in = 32'h20;
    @(posedge clk_in); #2;
    roll_back = 1'b0;
    wait_push_pc(32'h20, w, pr);
    chk("beq_trained_pred", {31'h0, pr}, 32'h1);
    wait_req(a);
    chk("beq_trained_next", a, 32'h1C);

    // roll_back mid-WAIT; response arrives two cycles later and is dropped.
    lat = 3;
    wait_req(a);
    @(posedge clk_in); #2;
    roll_back = 1'b1; roll_back_pc_in = 32'h100;
    @(posedge clk_in); #2;
    roll_back = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("flush_no_push", {31'h0, instruction_ready}, 32'h0);
      if (i < 2) begin
        chk("flush_req_held", {31'h0, icache_req_out}, 32'h1);
        chk("flush_old_addr", icache_addr_out, a);
      end
    end
    wait_req(a);
    chk("rollback_addr", a, 32'h100);
    wait_push(w, p, pr, t1);
    chk("rollback_push_pc", p, 32'h100);

    // Queue full blocks new requests.
    lat = 1;
    wait_push(w, p, pr, t1);
    @(posedge clk_in); #2;
    isq_full_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      chk("full_no_req", {31'h0, icache_req_out}, 32'h0);
    end
    @(posedge clk_in); #2;
    isq_full_in = 1'b0;
    @(negedge clk_in);
    chk("full_release_edge", {31'h0, icache_req_out}, 32'h0);
    @(negedge clk_in);
    chk("full_release_req", {31'h0, icache_req_out}, 32'h1);

    // rdy_in low for three cycles mid-WAIT.
    lat = 3;
    wait_req(a);
    @(posedge clk_in); #2;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("frz_req", {31'h0, icache_req_out}, 32'h1);
      chk("frz_addr", icache_addr_out, a);
      chk("frz_ready", {31'h0, instruction_ready}, 32'h0);
    end
    @(posedge clk_in); #2;
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("frz_last_req", {31'h0, icache_req_out}, 32'h1);
    chk("frz_last_ready", {31'h0, instruction_ready}, 32'h0);
    wait_push(w, p, pr, t1);
    chk("frz_push_pc", p, a);

    repeat (3) @(negedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
